bus_capture_buffer: RTL and testbench
=====================================

Name: bus_capture_buffer

Overview:
- Receiving end of a shared 3-state data bus driven by one or more octal buffer/line drivers.
- Captures the bus word on an active-LOW load strobe and queues it in a small first-word-fall-through buffer with a valid/ack read handshake.
- At each capture, checks the drivers' output-enable lines and flags a floating bus (no driver) or bus contention (more than one driver).
- Used by CPU datapath registers and I/O ports that listen on the bus.

Parameters:
- WIDTH, 8: bus and entry width in bits.
- NDRV, 4: number of bus drivers monitored.
- DEPTH, 2: buffer entries; power of 2, at least 2.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- BUS  input  WIDTH  shared 3-state data bus.
- DRV_OE_bar  input  NDRV  one bit per driver; LOW = that driver is actively driving BUS (both of its enables asserted).
- LOAD_bar  input  1  active-LOW capture strobe, sampled synchronously.
- ACK  input  1  consumer pops the head entry.
- CLR_ERR  input  1  clears the sticky error flags.
- Q  output  WIDTH  head entry (first-word-fall-through).
- VALID  output  1  buffer non-empty.
- FULL  output  1  count == DEPTH.
- COUNT  output  clog2(DEPTH+1)  number of entries held.
- OVERRUN  output  1  sticky: a valid capture was dropped because the buffer was full.
- FLOAT_ERR  output  1  sticky: a capture occurred with no driver enabled.
- CONTENTION_ERR  output  1  sticky: a capture occurred with more than one driver enabled.

Behaviour:
- All state updates on the rising CLK edge. RST is synchronous, active-high, and takes priority over everything.
- Reset values:
  - pointers, COUNT, all flags = 0; storage = 0.
  - so Q = 0, VALID = 0, FULL = 0.
  - strobe history register load_q = 1.
- Capture event: LOAD_bar == 0 at this edge and load_q == 1 (falling edge detected on sampled values); load_q <= LOAD_bar every cycle.
  - LOAD_bar held low for many cycles gives exactly one capture.
  - LOAD_bar held low through reset release gives no capture until it rises and falls again.
- At a capture event, ndrv = number of 0 bits in DRV_OE_bar, sampled at the same edge as BUS.
  - ndrv == 0: FLOAT_ERR <= 1; nothing written.
  - ndrv > 1: CONTENTION_ERR <= 1; nothing written.
  - ndrv == 1 and a slot is free: BUS written at the write pointer; write pointer +1 modulo DEPTH.
  - ndrv == 1 and no slot is free: OVERRUN <= 1; word dropped.
- Slot free = COUNT < DEPTH, or (ACK && VALID) in the same cycle. Simultaneous pop and push when full is accepted and COUNT stays DEPTH.
- Read side:
  - Q = storage[read pointer], combinational from registers.
  - VALID = (COUNT != 0).
  - ACK && VALID: read pointer +1 modulo DEPTH.
  - ACK while !VALID: ignored, no state change.
  - Q holds its value while !ACK.
- COUNT: +1 on an accepted push only, -1 on a pop only, unchanged on both or neither.
- Latency: capture at edge N gives VALID = 1 and Q = word after edge N. On an empty buffer there is no extra cycle.
- Pointers wrap modulo DEPTH with no gap; FULL and VALID derive from COUNT only.
- Error flags are sticky until CLR_ERR == 1 at an edge. If CLR_ERR and a new error occur at the same edge, the flag is set (set wins). CLR_ERR does not affect buffer contents.
- Only captured data is registered. BUS X/Z values are stored as-is; no bus value is used when ndrv != 1.

Test Plan:
- Reset with LOAD_bar = 0 held: RST high 2 cycles, release with LOAD_bar still 0 -> no capture, COUNT = 0, VALID = 0, Q = 0x00, all flags 0; raise then lower LOAD_bar with BUS = 0x5A and DRV_OE_bar = 4'b1110 -> next cycle VALID = 1, Q = 0x5A, COUNT = 1.
- Single-driver burst: captures of 0x11 then 0x22 (DRV_OE_bar = 4'b1011), no ACK -> FULL = 1, COUNT = 2, Q = 0x11; third capture of 0x33 -> OVERRUN = 1, contents unchanged; ACK twice -> Q = 0x22 then VALID = 0.
- Push and pop while full: FULL with 0x11/0x22, capture 0x44 with ACK at the same edge -> COUNT = 2, Q = 0x22, OVERRUN = 0, next ACK -> Q = 0x44.
- Floating bus: capture with DRV_OE_bar = 4'b1111 -> FLOAT_ERR = 1, COUNT unchanged; CLR_ERR pulse -> FLOAT_ERR = 0.
- Contention: capture with DRV_OE_bar = 4'b1100 -> CONTENTION_ERR = 1, nothing written; a contention capture together with CLR_ERR at the same edge -> CONTENTION_ERR remains 1.
- Wrap-around: 10 push/pop cycles with values 0x00..0x09 at DEPTH = 2 -> Q sequence exactly 0x00..0x09, no flags set; ACK on empty buffer -> no change.

Source files
------------

// File: rtl/bus_capture_buffer.sv
// bus_capture_buffer: captures a 3-state bus word on a LOAD_bar falling edge into a FWFT buffer, flagging float/contention.
module bus_capture_buffer #(
  parameter int WIDTH = 8,
  parameter int NDRV  = 4,
  parameter int DEPTH = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [WIDTH-1:0]               BUS,
  input  logic [NDRV-1:0]                DRV_OE_bar,
  input  logic                           LOAD_bar,
  input  logic                           ACK,
  input  logic                           CLR_ERR,
  output logic [WIDTH-1:0]               Q,
  output logic                           VALID,
  output logic                           FULL,
  output logic [$clog2(DEPTH+1)-1:0]     COUNT,
  output logic                           OVERRUN,
  output logic                           FLOAT_ERR,
  output logic                           CONTENTION_ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             load_q, rst_q;
  logic             none, single, capture, pop, push, drop;
  // rst_q masks the edge seen when LOAD_bar is already low as reset releases
  assign capture = !LOAD_bar && load_q && !rst_q;
  assign none    = &DRV_OE_bar;
  assign single  = $onehot(~DRV_OE_bar);
  assign pop     = ACK && VALID;
  assign push    = capture && single && (!FULL || pop);
  assign drop    = capture && single && FULL && !pop;
  assign Q       = mem[rd_ptr];
  assign VALID   = COUNT != '0;
  assign FULL    = COUNT == CW'(DEPTH);
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      COUNT          <= '0;
      load_q         <= 1'b1;
      rst_q          <= 1'b1;
      OVERRUN        <= 1'b0;
      FLOAT_ERR      <= 1'b0;
      CONTENTION_ERR <= 1'b0;
    end else begin
      load_q <= LOAD_bar;
      rst_q  <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= BUS;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      COUNT          <= COUNT + CW'(push) - CW'(pop);
      OVERRUN        <= drop || (OVERRUN && !CLR_ERR);
      FLOAT_ERR      <= (capture && none) || (FLOAT_ERR && !CLR_ERR);
      CONTENTION_ERR <= (capture && !none && !single) || (CONTENTION_ERR && !CLR_ERR);
    end
  end
endmodule

// File: tb/tb_bus_capture_buffer.sv
// tb_bus_capture_buffer: directed checks of capture, FWFT handshake, overrun and bus-driver error flags.
module tb_bus_capture_buffer;
  logic       clk = 0;
  logic       rst, load_bar, ack, clr_err;
  logic [7:0] bus;
  logic [3:0] drv_oe_bar;
  logic [7:0] q;
  logic       valid, full, overrun, float_err, contention_err;
  logic [1:0] count;
  int checks = 0, errors = 0;

  bus_capture_buffer #(.WIDTH(8), .NDRV(4), .DEPTH(2)) dut (
    .CLK(clk), .RST(rst), .BUS(bus), .DRV_OE_bar(drv_oe_bar), .LOAD_bar(load_bar),
    .ACK(ack), .CLR_ERR(clr_err), .Q(q), .VALID(valid), .FULL(full), .COUNT(count),
    .OVERRUN(overrun), .FLOAT_ERR(float_err), .CONTENTION_ERR(contention_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input logic [7:0] d, input logic [3:0] oe, input logic a);
    bus = d; drv_oe_bar = oe; load_bar = 0; ack = a;
    step();
    load_bar = 1; ack = 0;
    step();
  endtask

  task automatic pop();
    ack = 1;
    step();
    ack = 0;
  endtask

  task automatic clr();
    clr_err = 1;
    step();
    clr_err = 0;
  endtask

  task automatic flags(input string tag, input logic [2:0] exp);
    chk(tag, {overrun, float_err, contention_err}, exp);
  endtask

  initial begin
    rst = 1; load_bar = 0; ack = 0; clr_err = 0; bus = 8'hA5; drv_oe_bar = 4'b1111;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_q", q, 8'h00);
    chk("rst_full", full, 0);
    flags("rst_flags", 3'b000);
    rst = 0;
    step(); step();
    chk("rel_count", count, 0);
    chk("rel_valid", valid, 0);
    chk("rel_q", q, 8'h00);
    flags("rel_flags", 3'b000);
    load_bar = 1;
    step();
    bus = 8'h5A; drv_oe_bar = 4'b1110; load_bar = 0;
    step();
    chk("lat_valid", valid, 1);
    chk("lat_q", q, 8'h5A);
    chk("lat_count", count, 1);
    load_bar = 1;
    pop();
    chk("lat_pop_valid", valid, 0);

    cap(8'h11, 4'b1011, 0);
    cap(8'h22, 4'b1011, 0);
    chk("burst_full", full, 1);
    chk("burst_count", count, 2);
    chk("burst_q", q, 8'h11);
    cap(8'h33, 4'b1011, 0);
    flags("ovr_flags", 3'b100);
    chk("ovr_count", count, 2);
    chk("ovr_q", q, 8'h11);
    pop();
    chk("pop1_q", q, 8'h22);
    chk("pop1_count", count, 1);
    chk("pop1_full", full, 0);
    pop();
    chk("pop2_valid", valid, 0);
    clr();
    flags("ovr_clr", 3'b000);

    cap(8'h11, 4'b1011, 0);
    cap(8'h22, 4'b1011, 0);
    cap(8'h44, 4'b1011, 1);
    chk("pp_count", count, 2);
    chk("pp_q", q, 8'h22);
    flags("pp_flags", 3'b000);
    pop();
    chk("pp_pop_q", q, 8'h44);
    pop();
    chk("pp_empty", valid, 0);

    cap(8'h77, 4'b1111, 0);
    flags("float_set", 3'b010);
    chk("float_count", count, 0);
    clr();
    flags("float_clr", 3'b000);

    cap(8'h66, 4'b1100, 0);
    flags("cont_set", 3'b001);
    chk("cont_count", count, 0);
    chk("cont_valid", valid, 0);
    bus = 8'h67; drv_oe_bar = 4'b0000; load_bar = 0; clr_err = 1;
    step();
    flags("cont_setwins", 3'b001);
    chk("cont_sw_count", count, 0);
    load_bar = 1; clr_err = 0;
    step();
    clr();
    flags("cont_clr", 3'b000);

    for (int i = 0; i < 10; i++) begin
      cap(8'(i), 4'b1110, 0);
      chk($sformatf("wrap_q%0d", i), q, 32'(i));
      chk($sformatf("wrap_cnt%0d", i), count, 1);
      pop();
      chk($sformatf("wrap_empty%0d", i), valid, 0);
    end
    flags("wrap_flags", 3'b000);
    chk("wrap_q_hold", q, 8'h08);
    pop();
    chk("ack_empty_count", count, 0);
    chk("ack_empty_valid", valid, 0);
    chk("ack_empty_q", q, 8'h08);
    flags("ack_empty_flags", 3'b000);
    cap(8'hC3, 4'b0111, 0);
    chk("post_q", q, 8'hC3);
    chk("post_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
